field_unpacker: RTL and testbench
=================================

// Module: field_unpacker
// PURPOSE
//   Receive end of the 6x5-bit field packing format: accepts a byte stream and rebuilds
//   the six 5-bit fields from each 32-bit word.
//   Word layout, MSB first: {f1,f2,f3,f4,f5,f6,MARKER}. Byte 0 = bits[31:24].
//   The block validates the 2-bit trailer marker on every word.
//   - Good word: presents all six fields in parallel behind a valid/ready handshake.
//   - Bad word: drops it and flags an error.
// PARAMETERS
//   MARKER     2'b11  required value of word bits[1:0]
//   ERR_CNT_W  8      width of the error counter (only with FU_ERR_COUNT_EN)
// PORTS
//   clk        in   1  rising-edge clock
//   reset      in   1  asynchronous, active-high reset
//   in_byte    in   8  incoming byte
//   in_valid   in   1  in_byte is valid this cycle
//   in_ready   out  1  block accepts in_byte this cycle
//   out_1..6   out  5  unpacked fields; out_1 = word bits[31:27], out_6 = bits[6:2]
//   out_valid  out  1  out_1..6 hold a complete good word
//   out_ready  in   1  downstream consumes the word this cycle
//   frame_err  out  1  one-cycle pulse when a word fails the marker check
//   err_count  out  ERR_CNT_W  saturating bad-word count (only with FU_ERR_COUNT_EN)
// BEHAVIOUR
//   Reset (async, reset=1), effective immediately:
//     - out_1..6, out_valid, frame_err, err_count = 0
//     - byte index = 0; any partial word is discarded
//   Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//   in_ready = ~out_valid | out_ready (combinational). Stalls only while a word is held.
//   Byte index (2 bits) increments on each in_fire and wraps 3 -> 0.
//   Accepted bytes shift into a 32-bit assembly register, MSB first.
//   On in_fire with index==3 (word complete, W = assembled 32 bits):
//     - W[1:0]==MARKER:
//         next cycle out_valid=1 and out_1..6 load W[31:2]
//         latency = 1 clock from the 4th byte accepted
//     - W[1:0]!=MARKER:
//         frame_err=1 for exactly the next cycle; fields and out_valid unchanged
//         the word is dropped; the index still wraps to 0
//   Field outputs hold their value while out_valid=1 and out_ready=0.
//   out_fire with no new word completing: out_valid -> 0 next cycle. Fields keep
//     their last value; they are don't-care while out_valid=0.
//   Same cycle out_fire + completing good word: out_valid stays 1 and the fields
//     load the new word. No bubble, no loss.
//   Same cycle out_fire + completing bad word: out_valid -> 0 and frame_err pulses.
//   in_valid=0 between bytes is legal. Partial words persist indefinitely; there is
//     no timeout.
//   Reset asserted mid-word or mid-hold: everything is abandoned. The first byte
//     accepted after reset is byte 0.
// CONFIGURATION
//   `define FU_ERR_COUNT_EN
//     With it:
//       - err_count port exists
//       - increments on each frame_err pulse and saturates at all-ones (no wrap)
//       - cleared only by reset
//     Without it:
//       - err_count port and its logic are absent
//       - frame_err behaviour is unchanged
// TESTING
//   1. Bytes 00,46,77,FF, back-to-back, out_ready=1:
//        out_valid=1 one cycle after FF
//        out_1..6 = 0,1,3,7,15,31; frame_err never asserts
//   2. Bytes 00,46,77,FE:
//        frame_err=1 for one cycle; out_valid stays 0
//        next 00,46,77,FF decodes correctly (index realigned)
//   3. out_ready=0 after test 1's word, then send 4 more bytes:
//        in_ready=0; fields stay 0,1,3,7,15,31
//        raising out_ready accepts the new word with no byte lost
//   4. Streamed words, out_ready=1, in_valid=1 every cycle:
//        in_ready stays 1; out_valid never drops between consecutive good words
//   5. Reset pulse after bytes 00,46:
//        all outputs 0; then FF,FF,FF,FF -> fields 31,31,31,31,31,31
//   6. FU_ERR_COUNT_EN, ERR_CNT_W=2:
//        5 bad words -> err_count 1,2,3,3,3
//        reset -> err_count = 0

Source files
------------

// File: rtl/field_unpacker.sv
// rtl/field_unpacker.sv - byte stream to six 5-bit field word unpacker; optional FU_ERR_COUNT_EN adds err_count
module field_unpacker #(
   parameter logic [1:0] MARKER = 2'b11
`ifdef FU_ERR_COUNT_EN
   , parameter int unsigned ERR_CNT_W = 8
`endif
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] in_byte,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [4:0] out_1,
   output logic [4:0] out_2,
   output logic [4:0] out_3,
   output logic [4:0] out_4,
   output logic [4:0] out_5,
   output logic [4:0] out_6,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       frame_err
`ifdef FU_ERR_COUNT_EN
   , output logic [ERR_CNT_W-1:0] err_count
`endif
);

   logic [1:0]  idx_q, idx_d;
   logic [23:0] asm_q, asm_d;
   logic [29:0] fld_q, fld_d;
   logic        ov_q, ov_d;
   logic        ferr_q, ferr_d;

   logic        in_fire;
   logic        out_fire;
   logic        word_done;
   logic        word_good;
   logic [31:0] word;

   // The 4th byte completes the word combinationally with the three buffered bytes.
   assign in_ready  = ~ov_q | out_ready;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = ov_q & out_ready;
   assign word      = {asm_q, in_byte};
   assign word_done = in_fire & (idx_q == 2'd3);
   assign word_good = (word[1:0] == MARKER);

   // Next-state: byte assembly, output hold/release, marker check.
   always_comb begin
      idx_d  = idx_q;
      asm_d  = asm_q;
      fld_d  = fld_q;
      ov_d   = ov_q;
      ferr_d = 1'b0;
      if (in_fire) begin
         idx_d = idx_q + 2'd1;
         asm_d = {asm_q[15:0], in_byte};
      end
      if (out_fire) begin
         ov_d = 1'b0;
      end
      if (word_done) begin
         if (word_good) begin
            ov_d  = 1'b1;
            fld_d = word[31:2];
         end else begin
            ferr_d = 1'b1;
         end
      end
   end

   // State registers; reset abandons any partial or held word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_q  <= 2'd0;
         asm_q  <= 24'd0;
         fld_q  <= 30'd0;
         ov_q   <= 1'b0;
         ferr_q <= 1'b0;
      end else begin
         idx_q  <= idx_d;
         asm_q  <= asm_d;
         fld_q  <= fld_d;
         ov_q   <= ov_d;
         ferr_q <= ferr_d;
      end
   end

   assign out_1     = fld_q[29:25];
   assign out_2     = fld_q[24:20];
   assign out_3     = fld_q[19:15];
   assign out_4     = fld_q[14:10];
   assign out_5     = fld_q[9:5];
   assign out_6     = fld_q[4:0];
   assign out_valid = ov_q;
   assign frame_err = ferr_q;

`ifdef FU_ERR_COUNT_EN
   logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

   // Count moves in the same cycle frame_err rises; sticks at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (word_done && !word_good && (cnt_q != {ERR_CNT_W{1'b1}})) begin
         cnt_d = cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Error counter register, cleared only by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign err_count = cnt_q;
`endif

endmodule

// File: tb/tb_field_unpacker.sv
// tb/tb_field_unpacker.sv - randomized and directed bench for field_unpacker against a word-level model
`timescale 1ns/1ps
module tb_field_unpacker;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] in_byte;
   logic       in_valid;
   logic       in_ready;
   logic [4:0] out_1, out_2, out_3, out_4, out_5, out_6;
   logic       out_valid;
   logic       out_ready;
   logic       frame_err;

   always #5 clk = ~clk;

`ifdef FU_ERR_COUNT_EN
   localparam int CW = 2;
   logic [CW-1:0] err_count;
   field_unpacker #(.MARKER(2'b11), .ERR_CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
      .out_1(out_1), .out_2(out_2), .out_3(out_3), .out_4(out_4), .out_5(out_5), .out_6(out_6),
      .out_valid(out_valid), .out_ready(out_ready), .frame_err(frame_err), .err_count(err_count));
`else
   field_unpacker #(.MARKER(2'b11)) dut (
      .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
      .out_1(out_1), .out_2(out_2), .out_3(out_3), .out_4(out_4), .out_5(out_5), .out_6(out_6),
      .out_valid(out_valid), .out_ready(out_ready), .frame_err(frame_err));
`endif

   logic [4:0] dut_f [6];
   assign dut_f[0] = out_1;
   assign dut_f[1] = out_2;
   assign dut_f[2] = out_3;
   assign dut_f[3] = out_4;
   assign dut_f[4] = out_5;
   assign dut_f[5] = out_6;

   // Reference model: bytes collected in a queue, word decoded by field position.
   logic [7:0] acc [$];
   bit         m_ov;
   bit         m_ferr;
   logic [4:0] m_f [6];
   int         m_cnt;

   int n_checks = 0;
   int n_bad    = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic check_outputs();
      check_eq("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
      check_eq("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
      if (m_ov) begin
         for (int k = 0; k < 6; k++) check_eq($sformatf("out_%0d", k + 1), {27'd0, dut_f[k]}, {27'd0, m_f[k]});
      end
`ifdef FU_ERR_COUNT_EN
      check_eq("err_count", {30'd0, err_count}, m_cnt);
`endif
   endtask

   task automatic check_fields_const(input string tag, input int e0, input int e1, input int e2,
                                     input int e3, input int e4, input int e5);
      int e [6];
      e = '{e0, e1, e2, e3, e4, e5};
      for (int k = 0; k < 6; k++) check_eq($sformatf("%s_f%0d", tag, k + 1), {27'd0, dut_f[k]}, e[k]);
   endtask

   task automatic model_reset();
      acc.delete();
      m_ov   = 0;
      m_ferr = 0;
      for (int k = 0; k < 6; k++) m_f[k] = 5'd0;
      m_cnt  = 0;
   endtask

   // One cycle: check the state from the last edge, drive, check in_ready, advance model.
   task automatic tick(input bit iv, input logic [7:0] b, input bit ordy, output bit fired);
      bit          exp_ir;
      logic [31:0] w;
      @(negedge clk);
      check_outputs();
      in_valid  = iv;
      in_byte   = b;
      out_ready = ordy;
      #1;
      exp_ir = !m_ov || ordy;
      check_eq("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
      fired  = iv && exp_ir;
      m_ferr = 0;
      if (m_ov && ordy) m_ov = 0;
      if (fired) begin
         acc.push_back(b);
         if (acc.size() == 4) begin
            w = {acc[0], acc[1], acc[2], acc[3]};
            acc.delete();
            if (w[1:0] == 2'b11) begin
               m_ov = 1;
               for (int k = 0; k < 6; k++) m_f[k] = w[31 - 5 * k -: 5];
            end else begin
               m_ferr = 1;
               if (m_cnt < 3) m_cnt++;
            end
         end
      end
   endtask

   task automatic send_word(input logic [31:0] w, input bit ordy);
      bit f;
      for (int k = 0; k < 4; k++) begin
         f = 0;
         for (int t = 0; t < 50 && !f; t++) tick(1'b1, w[31 - 8 * k -: 8], ordy, f);
         if (!f) check_eq("accept_timeout", 32'd0, 32'd1);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b1;
      in_valid = 1'b0;
      #1;
      model_reset();
      check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("rst_frame_err", {31'd0, frame_err}, 32'd0);
      check_fields_const("rst", 0, 0, 0, 0, 0, 0);
`ifdef FU_ERR_COUNT_EN
      check_eq("rst_err_count", {30'd0, err_count}, 32'd0);
`endif
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      bit f;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_byte   = 8'h00;
      out_ready = 1'b1;
      model_reset();
      #12;
      check_eq("por_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("por_frame_err", {31'd0, frame_err}, 32'd0);
      check_fields_const("por", 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      reset = 1'b0;

      // Basic good word
      send_word(32'h004677FF, 1'b1);
      tick(1'b0, 8'h00, 1'b0, f);
      check_eq("t1_valid", {31'd0, out_valid}, 32'd1);
      check_fields_const("t1", 0, 1, 3, 7, 15, 31);

      // Back-pressure: bytes offered while held are not taken
      for (int i = 0; i < 4; i++) tick(1'b1, 8'hA5, 1'b0, f);
      check_eq("t3_in_ready", {31'd0, in_ready}, 32'd0);
      check_fields_const("t3", 0, 1, 3, 7, 15, 31);
      send_word(32'h8421_0843, 1'b1);
      tick(1'b0, 8'h00, 1'b1, f);
      check_fields_const("t3b", 16, 16, 16, 16, 16, 16);

      // Bad marker then realigned good word
      send_word(32'h004677FE, 1'b1);
      tick(1'b0, 8'h00, 1'b1, f);
      check_eq("t2_ferr", {31'd0, frame_err}, 32'd1);
      check_eq("t2_valid", {31'd0, out_valid}, 32'd0);
      tick(1'b0, 8'h00, 1'b1, f);
      check_eq("t2_ferr_once", {31'd0, frame_err}, 32'd0);
      send_word(32'h004677FF, 1'b1);
      tick(1'b0, 8'h00, 1'b0, f);
      check_fields_const("t2b", 0, 1, 3, 7, 15, 31);

      // Streamed words, no bubble
      for (int i = 0; i < 6; i++) send_word({$urandom, 2'b11}, 1'b1);
      tick(1'b0, 8'h00, 1'b1, f);

      // Reset mid-word
      tick(1'b1, 8'h00, 1'b1, f);
      tick(1'b1, 8'h46, 1'b1, f);
      do_reset();
      send_word(32'hFFFFFFFF, 1'b1);
      tick(1'b0, 8'h00, 1'b0, f);
      check_fields_const("t5", 31, 31, 31, 31, 31, 31);
      tick(1'b0, 8'h00, 1'b1, f);

`ifdef FU_ERR_COUNT_EN
      do_reset();
      for (int i = 0; i < 5; i++) begin
         send_word(32'h12345670 | i, 1'b1);
         tick(1'b0, 8'h00, 1'b1, f);
         check_eq($sformatf("t6_cnt%0d", i), {30'd0, err_count}, (i < 3) ? i + 1 : 3);
      end
      do_reset();
`endif

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         logic [7:0] b;
         b = 8'($urandom);
         if ($urandom_range(3) != 0) b[1:0] = 2'b11;
         tick($urandom_range(3) != 0, b, $urandom_range(2) != 0, f);
         if (i == 1500) do_reset();
      end
      tick(1'b0, 8'h00, 1'b1, f);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
